fir_frame_collector: RTL and testbench

- Receiving end of the FIR output stream (fir_valid/fir_d). Collects consecutive filtered samples into 16-sample frames.
- Presents each complete frame in parallel to the downstream FFT stage through a valid/ready handshake.
- Ping-pong storage of two banks, so collection continues while the FFT holds a frame.
- Reports dropped samples and counts delivered frames.

---
 rtl/fir_frame_collector_if.sv | 26 ++
 rtl/fir_frame_collector.sv | 83 ++++++++
 tb/tb_fir_frame_collector.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fir_frame_collector_if.sv
// Handshake bundle between the FIR output stream, the frame collector
// and the downstream FFT stage.
interface fir_frame_collector_if #(
  parameter int DW = 16,
  parameter int N  = 16
);
  logic              fir_valid;
  logic [DW-1:0]     fir_d;
  logic              frm_ready;
  logic              frm_valid;
  logic [N*DW-1:0]   frm_data;
  logic [7:0]        frm_cnt;
  logic              overflow;

  // Producer/consumer side: drives samples and frame acceptance.
  modport master (
    output fir_valid, fir_d, frm_ready,
    input  frm_valid, frm_data, frm_cnt, overflow
  );

  // Collector side.
  modport slave (
    input  fir_valid, fir_d, frm_ready,
    output frm_valid, frm_data, frm_cnt, overflow
  );
endinterface

// File: rtl/fir_frame_collector.sv
// Collects FIR samples into N-sample frames held in two ping-pong banks and
// presents each complete frame in parallel through a valid/ready handshake.
// Samples arriving while both banks are occupied are dropped and flagged.
module fir_frame_collector #(
  parameter int DW = 16,
  parameter int N  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fir_frame_collector_if.slave  bus
);

  localparam int PW = $clog2(N);

  logic [DW-1:0] mem [2][N];
  logic [PW-1:0] wptr;
  logic          wbank;
  logic          rbank;
  logic [1:0]    full;
  logic [7:0]    cnt;
  logic          ovf;
  logic          hs;

  // Frame taken by the consumer at this edge; only ever touches the bank
  // currently presented, which is full, so it never collides with the
  // write-side completion of the other (non-full) bank.
  assign hs = full[rbank] & bus.frm_ready;

  // Write pointer, bank state, delivery count and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      full  <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      // NOTE: the banks are reset on purpose: frm_data must read zero after
      // reset, so this storage cannot be left as uninitialised RAM.
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N; k++) begin
          mem[b][k] <= '0;
        end
      end
    end else begin
      // NOTE: full[] is tested on its registered value, so a bank released
      // by the handshake this cycle cannot accept a sample until next cycle.
      if (bus.fir_valid) begin
        if (!full[wbank]) begin
          mem[wbank][wptr] <= bus.fir_d;
          if (wptr == PW'(N - 1)) begin
            full[wbank] <= 1'b1;
            wbank       <= ~wbank;
            wptr        <= '0;
          end else begin
            wptr <= wptr + PW'(1);
          end
        end else begin
          ovf <= 1'b1;
        end
      end
      if (hs) begin
        full[rbank] <= 1'b0;
        rbank       <= ~rbank;
        cnt         <= cnt + 8'd1;
      end
    end
  end

  // Flatten the presented bank; slot 0 (oldest sample) sits in the low bits.
  always_comb begin
    // NOTE: default first so no path through this block can infer a latch.
    bus.frm_data = '0;
    for (int k = 0; k < N; k++) begin
      bus.frm_data[k*DW +: DW] = mem[rbank][k];
    end
  end

  assign bus.frm_valid = full[rbank];
  assign bus.frm_cnt   = cnt;
  assign bus.overflow  = ovf;

endmodule

// File: tb/tb_fir_frame_collector.sv
// Randomised and directed bench for fir_frame_collector. A frame-level model
// (queue of partial samples, count of held frames) predicts every delivered
// frame; a negedge monitor compares the DUT against it.
module tb_fir_frame_collector;

  localparam int DW = 16;
  localparam int N  = 16;
  localparam int FW = N * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fir_frame_collector_if #(.DW(DW), .N(N)) bus ();

  fir_frame_collector #(.DW(DW), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [DW-1:0] part [$];
  logic [FW-1:0] exp_q [$];
  int            pend_n = 0;
  logic          m_ovf  = 1'b0;
  logic [7:0]    m_cnt  = 8'd0;

  task automatic check(input string name, input logic [FW-1:0] act,
                       input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame-level rules: a sample is refused when two complete frames are
  // waiting (judged before this edge's handshake); the oldest waiting frame
  // leaves whenever the consumer is ready.
  task automatic model_edge(input logic v, input logic [DW-1:0] d,
                            input logic r);
    int            held;
    logic [FW-1:0] f;
    held = pend_n;
    if (v) begin
      if (held == 2) begin
        m_ovf = 1'b1;
      end else begin
        part.push_back(d);
        if (part.size() == N) begin
          for (int k = 0; k < N; k++) f[k*DW +: DW] = part[k];
          exp_q.push_back(f);
          part.delete();
          pend_n++;
        end
      end
    end
    if (r && held > 0) begin
      pend_n--;
      m_cnt++;
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    bus.fir_valid = v;
    bus.fir_d     = d;
    bus.frm_ready = r;
    @(posedge clk);
    model_edge(v, d, r);
    #1;
  endtask

  task automatic do_reset();
    bus.fir_valid = 1'b0;
    bus.fir_d     = '0;
    bus.frm_ready = 1'b0;
    rst = 1'b1;
    part.delete();
    exp_q.delete();
    pend_n = 0;
    m_ovf  = 1'b0;
    m_cnt  = 8'd0;
    #1;
    check("rst_frm_valid", FW'(bus.frm_valid), FW'(0));
    check("rst_overflow",  FW'(bus.overflow),  FW'(0));
    check("rst_frm_cnt",   FW'(bus.frm_cnt),   FW'(0));
    check("rst_frm_data",  bus.frm_data,       FW'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compares status every cycle and the presented frame against
  // the scoreboard head, popping it when the handshake will complete.
  always @(negedge clk) begin
    if (!rst) begin
      check("mon_frm_valid", FW'(bus.frm_valid), FW'(pend_n > 0));
      check("mon_overflow",  FW'(bus.overflow),  FW'(m_ovf));
      check("mon_frm_cnt",   FW'(bus.frm_cnt),   FW'(m_cnt));
      if (bus.frm_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL mon_unexpected_frame: got %h expected none",
                   bus.frm_data);
        end else begin
          check("mon_frm_data", bus.frm_data, exp_q[0]);
          if (bus.frm_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.fir_valid = 1'b0;
    bus.fir_d     = '0;
    bus.frm_ready = 1'b0;
    #2;
    do_reset();

    // Frame latency and slot order with a signed-range pattern.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, DW'(16'h8000 + i), 1'b1);
      if (i == 14) check("t2_not_yet_valid", FW'(bus.frm_valid), FW'(0));
    end
    check("t2_valid_after_16th", FW'(bus.frm_valid), FW'(1));
    check("t2_slot0",  FW'(bus.frm_data[15:0]),    FW'(16'h8000));
    check("t2_slot15", FW'(bus.frm_data[255:240]), FW'(16'h800F));
    check("t2_cnt_before_hs", FW'(bus.frm_cnt), FW'(0));
    step(1'b0, '0, 1'b1);
    check("t2_cnt_after_hs", FW'(bus.frm_cnt), FW'(1));

    // Alternating valid: nothing lost across gaps.
    for (int i = 0; i < 64; i++) step(i[0] == 1'b0, DW'(i / 2), 1'b1);
    step(1'b0, '0, 1'b1);
    check("t3_no_overflow", FW'(bus.overflow), FW'(0));
    check("t3_cnt", FW'(bus.frm_cnt), FW'(3));

    // Back-pressure: two frames held, samples 33..40 dropped.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, DW'(i), 1'b0);
    check("t4_overflow", FW'(bus.overflow), FW'(1));
    check("t4_head_slot0", FW'(bus.frm_data[15:0]), FW'(0));
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    check("t4_cnt", FW'(bus.frm_cnt), FW'(2));
    check("t4_drained", FW'(bus.frm_valid), FW'(0));

    // Release and incoming sample on the same edge: sample is dropped.
    do_reset();
    for (int i = 0; i < 32; i++) step(1'b1, DW'(i + 100), 1'b0);
    check("t5_ovf_clear", FW'(bus.overflow), FW'(0));
    step(1'b1, DW'(16'hAAAA), 1'b1);
    check("t5_ovf_set", FW'(bus.overflow), FW'(1));
    step(1'b1, DW'(16'h5555), 1'b0);
    for (int i = 1; i < 16; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b0, '0, 1'b1);
    check("t5_freed_valid", FW'(bus.frm_valid), FW'(1));
    check("t5_freed_slot0", FW'(bus.frm_data[15:0]), FW'(16'h5555));
    step(1'b0, '0, 1'b1);

    // Reset in the middle of a frame with overflow and count non-zero.
    for (int i = 0; i < 7; i++) step(1'b1, DW'(16'h0777), 1'b0);
    do_reset();
    for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b0);
    check("t1_valid", FW'(bus.frm_valid), FW'(1));
    check("t1_slot0",  FW'(bus.frm_data[15:0]),    FW'(16'h0001));
    check("t1_slot15", FW'(bus.frm_data[255:240]), FW'(16'h0010));
    step(1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) < 70, DW'($urandom),
           $urandom_range(0, 99) < 40);
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    check("rand_all_delivered", FW'(exp_q.size()), FW'(0));

    // Delivery counter wrap.
    do_reset();
    for (int i = 0; i < 256 * N; i++) step(1'b1, DW'($urandom), 1'b1);
    check("t6_cnt_255", FW'(bus.frm_cnt), FW'(255));
    step(1'b0, '0, 1'b1);
    check("t6_cnt_wrap", FW'(bus.frm_cnt), FW'(0));
    check("t6_no_overflow", FW'(bus.overflow), FW'(0));

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
